// File: rtl/bank_sc_if.sv
// ============================================================================
//  Module  : bank_sc_if
//  Purpose : Request (issue stage) and response handshake bundle for bank_sc.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface bank_sc_if;
    logic         isu_sc_valid_i;
    logic         isu_sc_ready_o;
    logic [1:0]   isu_sc_channel_id_i;
    logic [2:0]   isu_sc_opcode_i;
    logic [6:0]   isu_sc_set_way_offset_i;
    logic [7:0]   isu_sc_wbuffer_id_i;
    logic [2:0]   isu_sc_xbar_rob_num_i;
    logic [1:0]   isu_sc_cacheline_dirty_offset0_i;
    logic [1:0]   isu_sc_cacheline_dirty_offset1_i;
    logic [127:0] isu_sc_linefill_data_offset0_i;
    logic [127:0] isu_sc_linefill_data_offset1_i;

    logic         sc_rsp_valid_o;
    logic         sc_rsp_ready_i;
    logic [1:0]   sc_rsp_channel_id_o;
    logic [7:0]   sc_rsp_wbuffer_id_o;
    logic [2:0]   sc_rsp_xbar_rob_num_o;
    logic [2:0]   sc_rsp_opcode_o;
    logic [127:0] sc_rsp_data_offset0_o;
    logic [127:0] sc_rsp_data_offset1_o;
    logic [1:0]   sc_rsp_dirty_offset0_o;
    logic [1:0]   sc_rsp_dirty_offset1_o;
    logic         sc_err_o;

    modport slave (
        input  isu_sc_valid_i, isu_sc_channel_id_i, isu_sc_opcode_i,
               isu_sc_set_way_offset_i, isu_sc_wbuffer_id_i, isu_sc_xbar_rob_num_i,
               isu_sc_cacheline_dirty_offset0_i, isu_sc_cacheline_dirty_offset1_i,
               isu_sc_linefill_data_offset0_i, isu_sc_linefill_data_offset1_i,
               sc_rsp_ready_i,
        output isu_sc_ready_o, sc_rsp_valid_o, sc_rsp_channel_id_o, sc_rsp_wbuffer_id_o,
               sc_rsp_xbar_rob_num_o, sc_rsp_opcode_o, sc_rsp_data_offset0_o,
               sc_rsp_data_offset1_o, sc_rsp_dirty_offset0_o, sc_rsp_dirty_offset1_o,
               sc_err_o
    );

    modport master (
        output isu_sc_valid_i, isu_sc_channel_id_i, isu_sc_opcode_i,
               isu_sc_set_way_offset_i, isu_sc_wbuffer_id_i, isu_sc_xbar_rob_num_i,
               isu_sc_cacheline_dirty_offset0_i, isu_sc_cacheline_dirty_offset1_i,
               isu_sc_linefill_data_offset0_i, isu_sc_linefill_data_offset1_i,
               sc_rsp_ready_i,
        input  isu_sc_ready_o, sc_rsp_valid_o, sc_rsp_channel_id_o, sc_rsp_wbuffer_id_o,
               sc_rsp_xbar_rob_num_o, sc_rsp_opcode_o, sc_rsp_data_offset0_o,
               sc_rsp_data_offset1_o, sc_rsp_dirty_offset0_o, sc_rsp_dirty_offset1_o,
               sc_err_o
    );
endinterface

`default_nettype wire

// File: rtl/bank_sc.sv
// ============================================================================
//  Module  : bank_sc
//  Purpose : 64-line x 2-half cache data bank with dirty codes, 1-cycle read.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bank_sc (
    input  logic      clk_i,
    input  logic      rst_ni,
    bank_sc_if.slave  bus
);

    localparam int         LINES    = 64;
    localparam int         DATA_W   = 128;
    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_EVICT = 3'd2;

    logic              rsp_valid_q, rsp_valid_d;
    logic [1:0]        rsp_ch_q,    rsp_ch_d;
    logic [7:0]        rsp_wb_q,    rsp_wb_d;
    logic [2:0]        rsp_rob_q,   rsp_rob_d;
    logic [2:0]        rsp_op_q,    rsp_op_d;
    logic [DATA_W-1:0] rsp_d0_q,    rsp_d0_d;
    logic [DATA_W-1:0] rsp_d1_q,    rsp_d1_d;
    logic [1:0]        rsp_t0_q,    rsp_t0_d;
    logic [1:0]        rsp_t1_q,    rsp_t1_d;
    logic              err_q,       err_d;

    logic [DATA_W-1:0] data0_q  [LINES];
    logic [DATA_W-1:0] data1_q  [LINES];
    logic [1:0]        dirty0_q [LINES];
    logic [1:0]        dirty1_q [LINES];

    logic       w_ready, w_accept, w_is_write, w_is_evict, w_is_resp, w_is_rsvd, w_rsp_hs;
    logic [5:0] w_idx;

    assign w_ready    = !rsp_valid_q | bus.sc_rsp_ready_i;
    assign w_accept   = bus.isu_sc_valid_i & w_ready;
    assign w_idx      = bus.isu_sc_set_way_offset_i[6:1];
    assign w_is_write = (bus.isu_sc_opcode_i == OP_WRITE);
    assign w_is_evict = (bus.isu_sc_opcode_i == OP_EVICT);
    assign w_is_resp  = (bus.isu_sc_opcode_i == OP_READ) | w_is_evict;
    assign w_is_rsvd  = !w_is_write & !w_is_resp;
    assign w_rsp_hs   = rsp_valid_q & bus.sc_rsp_ready_i;

    // Data array carries no reset so it maps onto plain storage.
    always_ff @(posedge clk_i) begin
        if (w_accept && w_is_write) begin
            data0_q[w_idx] <= bus.isu_sc_linefill_data_offset0_i;
            data1_q[w_idx] <= bus.isu_sc_linefill_data_offset1_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LINES; i++) begin
                dirty0_q[i] <= 2'b00;
                dirty1_q[i] <= 2'b00;
            end
        end else if (w_accept && w_is_write) begin
            dirty0_q[w_idx] <= bus.isu_sc_cacheline_dirty_offset0_i;
            dirty1_q[w_idx] <= bus.isu_sc_cacheline_dirty_offset1_i;
        end else if (w_accept && w_is_evict) begin
            dirty0_q[w_idx] <= 2'b00;
            dirty1_q[w_idx] <= 2'b00;
        end
    end

    // A new read/evict takes priority over the drain so back-to-back responses stream.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_ch_d    = rsp_ch_q;
        rsp_wb_d    = rsp_wb_q;
        rsp_rob_d   = rsp_rob_q;
        rsp_op_d    = rsp_op_q;
        rsp_d0_d    = rsp_d0_q;
        rsp_d1_d    = rsp_d1_q;
        rsp_t0_d    = rsp_t0_q;
        rsp_t1_d    = rsp_t1_q;
        err_d       = w_accept & w_is_rsvd;
        if (w_accept && w_is_resp) begin
            rsp_valid_d = 1'b1;
            rsp_ch_d    = bus.isu_sc_channel_id_i;
            rsp_wb_d    = bus.isu_sc_wbuffer_id_i;
            rsp_rob_d   = bus.isu_sc_xbar_rob_num_i;
            rsp_op_d    = bus.isu_sc_opcode_i;
            rsp_d0_d    = data0_q[w_idx];
            rsp_d1_d    = data1_q[w_idx];
            rsp_t0_d    = dirty0_q[w_idx];
            rsp_t1_d    = dirty1_q[w_idx];
        end else if (w_rsp_hs) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_ch_q    <= '0;
            rsp_wb_q    <= '0;
            rsp_rob_q   <= '0;
            rsp_op_q    <= '0;
            rsp_d0_q    <= '0;
            rsp_d1_q    <= '0;
            rsp_t0_q    <= '0;
            rsp_t1_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_ch_q    <= rsp_ch_d;
            rsp_wb_q    <= rsp_wb_d;
            rsp_rob_q   <= rsp_rob_d;
            rsp_op_q    <= rsp_op_d;
            rsp_d0_q    <= rsp_d0_d;
            rsp_d1_q    <= rsp_d1_d;
            rsp_t0_q    <= rsp_t0_d;
            rsp_t1_q    <= rsp_t1_d;
            err_q       <= err_d;
        end
    end

    assign bus.isu_sc_ready_o         = w_ready;
    assign bus.sc_rsp_valid_o         = rsp_valid_q;
    assign bus.sc_rsp_channel_id_o    = rsp_ch_q;
    assign bus.sc_rsp_wbuffer_id_o    = rsp_wb_q;
    assign bus.sc_rsp_xbar_rob_num_o  = rsp_rob_q;
    assign bus.sc_rsp_opcode_o        = rsp_op_q;
    assign bus.sc_rsp_data_offset0_o  = rsp_d0_q;
    assign bus.sc_rsp_data_offset1_o  = rsp_d1_q;
    assign bus.sc_rsp_dirty_offset0_o = rsp_t0_q;
    assign bus.sc_rsp_dirty_offset1_o = rsp_t1_q;
    assign bus.sc_err_o               = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bank_sc.sv
// ============================================================================
//  Module  : tb_bank_sc
//  Purpose : Scoreboard bench for bank_sc (queue of expected responses).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bank_sc;

    typedef struct {
        logic [1:0]   ch;
        logic [7:0]   wb;
        logic [2:0]   rob;
        logic [2:0]   op;
        logic [127:0] d0;
        logic [127:0] d1;
        logic [1:0]   t0;
        logic [1:0]   t1;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bank_sc_if bus ();

    bank_sc u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    rsp_t         exp_q [$];
    rsp_t         mon_e;
    logic [127:0] m_d0 [64];
    logic [127:0] m_d1 [64];
    logic [1:0]   m_t0 [64];
    logic [1:0]   m_t1 [64];

    int cyc          = 0;
    int last_rsp_cyc = 0;
    int burst_cnt    = 0;
    int burst_gaps   = 0;
    bit burst_on     = 1'b0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Response monitor: a response is consumed at the edge following this sample.
    always @(negedge clk) begin
        if (rst_n && bus.sc_rsp_valid_o && bus.sc_rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                check_val("rsp_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("rsp_ch",  bus.sc_rsp_channel_id_o,    mon_e.ch);
                check_val("rsp_wb",  bus.sc_rsp_wbuffer_id_o,    mon_e.wb);
                check_val("rsp_rob", bus.sc_rsp_xbar_rob_num_o,  mon_e.rob);
                check_val("rsp_op",  bus.sc_rsp_opcode_o,        mon_e.op);
                check_val("rsp_d0",  bus.sc_rsp_data_offset0_o,  mon_e.d0);
                check_val("rsp_d1",  bus.sc_rsp_data_offset1_o,  mon_e.d1);
                check_val("rsp_t0",  bus.sc_rsp_dirty_offset0_o, mon_e.t0);
                check_val("rsp_t1",  bus.sc_rsp_dirty_offset1_o, mon_e.t1);
            end
            if (burst_on) begin
                if (burst_cnt > 0 && cyc != last_rsp_cyc + 1) burst_gaps++;
                burst_cnt++;
                last_rsp_cyc = cyc;
            end
        end
    end

    // Drives one request and returns at the negedge before the accepting edge.
    task automatic send(input logic [2:0] op, input logic [6:0] off,
                        input logic [127:0] d0, input logic [127:0] d1,
                        input logic [1:0] t0, input logic [1:0] t1,
                        input logic [2:0] rob, input logic [1:0] ch, input logic [7:0] wb);
        int   waitc;
        rsp_t e;
        logic [5:0] idx;
        @(posedge clk); #1;
        bus.isu_sc_valid_i                   = 1'b1;
        bus.isu_sc_opcode_i                  = op;
        bus.isu_sc_set_way_offset_i          = off;
        bus.isu_sc_linefill_data_offset0_i   = d0;
        bus.isu_sc_linefill_data_offset1_i   = d1;
        bus.isu_sc_cacheline_dirty_offset0_i = t0;
        bus.isu_sc_cacheline_dirty_offset1_i = t1;
        bus.isu_sc_xbar_rob_num_i            = rob;
        bus.isu_sc_channel_id_i              = ch;
        bus.isu_sc_wbuffer_id_i              = wb;
        @(negedge clk);
        waitc = 0;
        while (!bus.isu_sc_ready_o && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.isu_sc_ready_o) begin
            check_val("accept_timeout", 0, 1);
            return;
        end
        idx = off[6:1];
        if (op == 3'd0) begin
            m_d0[idx] = d0; m_d1[idx] = d1; m_t0[idx] = t0; m_t1[idx] = t1;
        end else if (op == 3'd1 || op == 3'd2) begin
            e.ch = ch; e.wb = wb; e.rob = rob; e.op = op;
            e.d0 = m_d0[idx]; e.d1 = m_d1[idx]; e.t0 = m_t0[idx]; e.t1 = m_t1[idx];
            exp_q.push_back(e);
            if (op == 3'd2) begin
                m_t0[idx] = 2'b00; m_t1[idx] = 2'b00;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.isu_sc_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        check_val(tag, exp_q.size(), 0);
    endtask

    initial begin
        bus.isu_sc_valid_i = 1'b0;
        bus.isu_sc_opcode_i = '0;
        bus.isu_sc_set_way_offset_i = '0;
        bus.isu_sc_linefill_data_offset0_i = '0;
        bus.isu_sc_linefill_data_offset1_i = '0;
        bus.isu_sc_cacheline_dirty_offset0_i = '0;
        bus.isu_sc_cacheline_dirty_offset1_i = '0;
        bus.isu_sc_xbar_rob_num_i = '0;
        bus.isu_sc_channel_id_i = '0;
        bus.isu_sc_wbuffer_id_i = '0;
        bus.sc_rsp_ready_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            m_t0[i] = 2'b00; m_t1[i] = 2'b00;
        end

        repeat (3) @(negedge clk);
        check_val("reset_rsp_valid", bus.sc_rsp_valid_o, 0);
        check_val("reset_err",       bus.sc_err_o, 0);
        check_val("reset_rsp_d0",    bus.sc_rsp_data_offset0_o, 0);
        check_val("reset_rsp_t1",    bus.sc_rsp_dirty_offset1_o, 0);
        rst_n = 1'b1;
        #1 check_val("ready_after_reset", bus.isu_sc_ready_o, 1);

        // Write then read line 5, latency 1
        send(3'd0, 7'd10, 128'h64, 128'h65, 2'b01, 2'b10, 3'd0, 2'd0, 8'h00);
        send(3'd1, 7'd10, '0, '0, 2'b00, 2'b00, 3'd3, 2'd2, 8'hA5);
        idle();
        @(negedge clk);
        check_val("read_latency", bus.sc_rsp_valid_o, 1);
        check_val("read_rob",     bus.sc_rsp_xbar_rob_num_o, 3);
        @(negedge clk);
        check_val("rsp_clears", bus.sc_rsp_valid_o, 0);

        // Backpressure: response held while not ready, aliased offset
        @(posedge clk); #1 bus.sc_rsp_ready_i = 1'b0;
        send(3'd1, 7'd11, '0, '0, 2'b00, 2'b00, 3'd6, 2'd1, 8'h3C);
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("stall_ready_low", bus.isu_sc_ready_o, 0);
            check_val("stall_valid",     bus.sc_rsp_valid_o, 1);
            check_val("stall_d0",        bus.sc_rsp_data_offset0_o, 128'h64);
            check_val("stall_rob",       bus.sc_rsp_xbar_rob_num_o, 6);
        end
        @(posedge clk); #1 bus.sc_rsp_ready_i = 1'b1;
        #1 check_val("ready_follows_rsp_ready", bus.isu_sc_ready_o, 1);
        @(negedge clk);
        @(negedge clk);
        check_val("stall_rsp_done", bus.sc_rsp_valid_o, 0);

        // Evict returns pre-evict dirty, following read sees cleared codes
        send(3'd2, 7'd10, '0, '0, 2'b00, 2'b00, 3'd1, 2'd0, 8'h11);
        send(3'd1, 7'd10, '0, '0, 2'b00, 2'b00, 3'd2, 2'd3, 8'h22);
        idle();
        wait_drain("evict_drain");

        // Reserved opcode: error pulse only
        send(3'd5, 7'd10, {4{32'hDEADBEEF}}, {4{32'hCAFEF00D}}, 2'b11, 2'b11, 3'd0, 2'd0, 8'h00);
        idle();
        @(negedge clk);
        check_val("err_pulse",    bus.sc_err_o, 1);
        check_val("err_no_rsp",   bus.sc_rsp_valid_o, 0);
        @(negedge clk);
        check_val("err_one_cycle", bus.sc_err_o, 0);
        send(3'd1, 7'd10, '0, '0, 2'b00, 2'b00, 3'd4, 2'd1, 8'h33);
        idle();
        wait_drain("err_read_drain");

        // Full sweep, then back-to-back reads through aliased offsets
        for (int i = 0; i < 64; i++) begin
            send(3'd0, 7'(2 * i), {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom},
                 2'($urandom), 2'($urandom), 3'd0, 2'd0, 8'h00);
        end
        idle();
        burst_cnt = 0; burst_gaps = 0; burst_on = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send(3'd1, 7'(2 * i + 1), '0, '0, 2'b00, 2'b00, 3'(i), 2'(i), 8'(i));
        end
        idle();
        wait_drain("burst_drain");
        burst_on = 1'b0;
        check_val("burst_count", burst_cnt, 64);
        check_val("burst_gaps",  burst_gaps, 0);

        // Reset in the middle of a pending response
        @(posedge clk); #1 bus.sc_rsp_ready_i = 1'b0;
        send(3'd1, 7'd20, '0, '0, 2'b00, 2'b00, 3'd7, 2'd2, 8'h44);
        idle();
        @(negedge clk);
        check_val("pre_reset_valid", bus.sc_rsp_valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_reset_valid", bus.sc_rsp_valid_o, 0);
        check_val("async_reset_rob",   bus.sc_rsp_xbar_rob_num_o, 0);
        check_val("async_reset_d0",    bus.sc_rsp_data_offset0_o, 0);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            m_t0[i] = 2'b00; m_t1[i] = 2'b00;
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.sc_rsp_ready_i = 1'b1;
        #1 check_val("ready_after_midreset", bus.isu_sc_ready_o, 1);
        send(3'd1, 7'd20,  '0, '0, 2'b00, 2'b00, 3'd1, 2'd0, 8'h55);
        send(3'd1, 7'd0,   '0, '0, 2'b00, 2'b00, 3'd2, 2'd1, 8'h66);
        send(3'd1, 7'd127, '0, '0, 2'b00, 2'b00, 3'd3, 2'd2, 8'h77);
        idle();
        wait_drain("post_reset_drain");

        repeat (2) @(negedge clk);
        check_val("final_idle", bus.sc_rsp_valid_o, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
